// File: rtl/booth_mult32_pkg.sv
// Shared constants and types for the radix-2 Booth multiplier and its adder.
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = $clog2(MULT_ITERS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITERS - 1);

    // Booth codes formed from {Q[0], q_m1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult32_if.sv
// Start/operand/result bundle between the execute stage and the multiplier.
interface booth_mult32_if;
    import mult_pkg::*;

    logic              ctrl_MULT;
    logic [MULT_W-1:0] data_operandA;
    logic [MULT_W-1:0] data_operandB;
    logic [MULT_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/booth_mult32_cla32bit.sv
// 32-bit add/subtract built from 4-bit carry-lookahead groups; sub inverts b and injects carry-in.
module cla32bit
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    input  logic              sub,
    output logic [MULT_W-1:0] sum,
    output logic              cout
);
    localparam int GROUPS = MULT_W / 4;

    logic [MULT_W-1:0] b_eff;
    logic [MULT_W-1:0] g;
    logic [MULT_W-1:0] p;
    logic [GROUPS:0]   gc;

    assign b_eff = b ^ {MULT_W{sub}};
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;
    assign gc[0] = sub;

    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
            logic [3:0] gg;
            logic [3:0] pp;
            logic [4:0] c;

            assign gg   = g[4*gi +: 4];
            assign pp   = p[4*gi +: 4];
            assign c[0] = gc[gi];
            assign c[1] = gg[0] | (pp[0] & c[0]);
            assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
            assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                        | (pp[2] & pp[1] & pp[0] & c[0]);
            assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);

            assign sum[4*gi +: 4] = pp ^ c[3:0];
            assign gc[gi+1]       = c[4];
        end
    endgenerate

    assign cout = gc[GROUPS];

endmodule

// File: rtl/booth_mult32.sv
// Sequential 32x32 signed radix-2 Booth multiplier: one step per clock, low word plus overflow flag.
module booth_mult32
    import mult_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    booth_mult32_if.slave        bus
);
    localparam int MSB = MULT_W - 1;

    state_t             state_reg, state_next;
    logic [MULT_W-1:0]  m_reg, m_next;
    logic [MULT_W-1:0]  a_reg, a_next;
    logic [MULT_W-1:0]  q_reg, q_next;
    logic               q_m1_reg, q_m1_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [MULT_W-1:0]  result_reg, result_next;
    logic               exception_reg, exception_next;
    logic               rdy_reg, rdy_next;

    logic [1:0]         booth;
    logic               sub;
    logic               use_adder;
    logic [MULT_W-1:0]  cla_sum;
    logic               cla_cout;
    logic [MULT_W-1:0]  step_sum;
    logic               sign_t;

    assign booth     = {q_reg[0], q_m1_reg};
    assign sub       = (booth == BOOTH_SUB);
    assign use_adder = (booth == BOOTH_ADD) || (booth == BOOTH_SUB);

    cla32bit u_cla (
        .a    (a_reg),
        .b    (m_reg),
        .sub  (sub),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Bit 32 of the sign-extended sum: equal to sum[31] ^ overflow, using the adder's carry-out.
    assign step_sum = use_adder ? cla_sum : a_reg;
    assign sign_t   = use_adder ? (a_reg[MSB] ^ (m_reg[MSB] ^ sub) ^ cla_cout) : a_reg[MSB];

    always_comb begin
        state_next     = state_reg;
        m_next         = m_reg;
        a_next         = a_reg;
        q_next         = q_reg;
        q_m1_next      = q_m1_reg;
        cnt_next       = cnt_reg;
        result_next    = result_reg;
        exception_next = exception_reg;
        rdy_next       = 1'b0;

        case (state_reg)
            ST_BUSY: begin
                a_next    = {sign_t, step_sum[MSB:1]};
                q_next    = {step_sum[0], q_reg[MSB:1]};
                q_m1_next = q_reg[0];
                cnt_next  = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                result_next    = q_reg;
                exception_next = (a_reg != {MULT_W{q_reg[MSB]}});
                rdy_next       = 1'b1;
                state_next     = ST_IDLE;
            end
            ST_IDLE: ;
            default: state_next = ST_IDLE;
        endcase

        // A start overrides the step/idle behaviour but still lets a finishing result publish.
        if (bus.ctrl_MULT) begin
            m_next     = bus.data_operandA;
            a_next     = '0;
            q_next     = bus.data_operandB;
            q_m1_next  = 1'b0;
            cnt_next   = '0;
            state_next = ST_BUSY;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            m_reg         <= '0;
            a_reg         <= '0;
            q_reg         <= '0;
            q_m1_reg      <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            rdy_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            m_reg         <= m_next;
            a_reg         <= a_next;
            q_reg         <= q_next;
            q_m1_reg      <= q_m1_next;
            cnt_reg       <= cnt_next;
            result_reg    <= result_next;
            exception_reg <= exception_next;
            rdy_reg       <= rdy_next;
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exception_reg;
    assign bus.data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_booth_mult32.sv
// Self-checking bench for booth_mult32: directed corner products, restart/reset cases, random back-to-back.
module tb_booth_mult32;
    import mult_pkg::*;

    localparam int LAT = 34;   // negedges from the driving negedge to the RDY negedge
    localparam int NB2B = 12;

    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    booth_mult32_if bus ();

    booth_mult32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_prod(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = ref_prod(a, b);
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
    endtask

    // Drops the strobe after the start edge and scrambles operands; returns 0 on timeout.
    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == 1) begin
                bus.ctrl_MULT     = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            if (bus.data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = ref_prod(a, b);
        check_eq({tag, " rdy"}, 64'(bus.data_resultRDY), 64'd1);
        check_eq({tag, " res"}, 64'(bus.data_result), 64'(p[31:0]));
        check_eq({tag, " exc"}, 64'(bus.data_exception), 64'(ref_ovf(a, b)));
        $display("%s: 0x%08h * 0x%08h -> 0x%08h exc=%0b", tag, a, b, bus.data_result, bus.data_exception);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] held;
        start_op(a, b);
        wait_rdy(lat);
        check_eq({tag, " lat"}, 64'(lat), 64'(LAT));
        check_result(tag, a, b);
        held = bus.data_result;
        repeat (2) @(negedge clock);
        check_eq({tag, " rdy drop"}, 64'(bus.data_resultRDY), 64'd0);
        check_eq({tag, " hold"}, 64'(bus.data_result), 64'(held));
    endtask

    initial begin
        logic [31:0] opa [NB2B];
        logic [31:0] opb [NB2B];
        logic [31:0] r;
        int lat;
        bit seen;

        // Reset asserted together with a start strobe: reset must win.
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd5;
        repeat (3) @(negedge clock);
        check_eq("reset res", 64'(bus.data_result), 64'd0);
        check_eq("reset exc", 64'(bus.data_exception), 64'd0);
        check_eq("reset rdy", 64'(bus.data_resultRDY), 64'd0);
        reset_n       = 1'b1;
        bus.ctrl_MULT = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= bus.data_resultRDY;
        end
        check_eq("reset start ignored", 64'(seen), 64'd0);

        do_op("3x5",        32'd3,        32'd5);
        do_op("-7x6",       32'hFFFFFFF9, 32'd6);
        do_op("-7x-6",      32'hFFFFFFF9, 32'hFFFFFFFA);
        do_op("maxx2",      32'h7FFFFFFF, 32'd2);
        do_op("minx-1",     32'h80000000, 32'hFFFFFFFF);
        do_op("minx1",      32'h80000000, 32'd1);
        do_op("0x0",        32'd0,        32'd0);
        do_op("minxmin",    32'h80000000, 32'h80000000);

        // Restart: re-strobe on the tenth edge after the first start.
        start_op(32'd3, 32'd5);
        seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (n == 1) bus.ctrl_MULT = 1'b0;
            seen |= bus.data_resultRDY;
        end
        start_op(32'd4, 32'd4);
        wait_rdy(lat);
        check_eq("restart early rdy", 64'(seen), 64'd0);
        check_eq("restart lat", 64'(lat), 64'(LAT));
        check_result("restart", 32'd4, 32'd4);
        @(negedge clock);

        // Reset mid-operation, applied at the fifteenth edge after start.
        start_op(32'd7, 32'd9);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            if (n == 1) bus.ctrl_MULT = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_eq("midrst res", 64'(bus.data_result), 64'd0);
        check_eq("midrst exc", 64'(bus.data_exception), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= bus.data_resultRDY;
        end
        check_eq("midrst no rdy", 64'(seen), 64'd0);
        do_op("2x9", 32'd2, 32'd9);

        // Random back-to-back, each new start on the edge that raises RDY.
        for (int i = 0; i < NB2B; i++) begin
            r = $urandom;
            opa[i] = (i % 3 == 0) ? {{16{r[15]}}, r[15:0]} : $urandom;
            r = $urandom;
            opb[i] = (i % 3 == 0) ? {{16{r[15]}}, r[15:0]} : $urandom;
        end
        start_op(opa[0], opb[0]);
        for (int i = 0; i < NB2B; i++) begin
            for (int n = 1; n <= 33; n++) begin
                @(negedge clock);
                if (n == 1) bus.ctrl_MULT = 1'b0;
                if (n == 1 && i > 0)
                    check_result($sformatf("b2b%0d", i - 1), opa[i-1], opb[i-1]);
                else
                    check_eq($sformatf("b2b%0d quiet", i), 64'(bus.data_resultRDY), 64'd0);
                if (n == 33 && i < NB2B - 1)
                    start_op(opa[i+1], opb[i+1]);
            end
        end
        @(negedge clock);
        check_result($sformatf("b2b%0d", NB2B - 1), opa[NB2B-1], opb[NB2B-1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
